nibble_bus_if: RTL

NIBBLE_BUS_IF -- requirements
Module: nibble_bus_if

---
 rtl/nibble_bus_if.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/nibble_bus_if.sv
// Host nibble-bus front end: synchronizes an asynchronous 4-bit host write port and
// assembles address/data nibbles into register writes. Optional macro: NIBBLE_BUS_AUTOINC_EN.
module nibble_bus_if #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] D,
  input  logic       A0,
  input  logic       WR,
  output logic       reg_we,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       half_pending
);

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0]            r_wr_sync;
  logic [SYNC_STAGES-1:0]            r_a0_sync;
  logic [SYNC_STAGES-1:0][NIB_W-1:0] r_d_sync;
  logic [SYNC_STAGES-1:0]            r_vld_sync;
  logic                              r_wr_hist;
  logic                              r_armed;

  state_t              r_state;
  logic [NIB_W-1:0]    r_addr;
  logic [NIB_W-1:0]    r_lo;
  logic                r_reg_we;
  logic [NIB_W-1:0]    r_reg_addr;
  logic [BYTE_W-1:0]   r_reg_data;
  logic                r_half_pending;

  logic                w_wr_s;
  logic                w_a0_s;
  logic [NIB_W-1:0]    w_d_s;
  logic                w_vld_s;
  logic                w_event;

  state_t              w_state_nx;
  logic [NIB_W-1:0]    w_addr_nx;
  logic [NIB_W-1:0]    w_lo_nx;
  logic                w_we_nx;
  logic [NIB_W-1:0]    w_reg_addr_nx;
  logic [BYTE_W-1:0]   w_reg_data_nx;

  assign w_wr_s  = r_wr_sync[SYNC_STAGES-1];
  assign w_a0_s  = r_a0_sync[SYNC_STAGES-1];
  assign w_d_s   = r_d_sync[SYNC_STAGES-1];
  assign w_vld_s = r_vld_sync[SYNC_STAGES-1];

  // Reset-cleared sync flops read as WR=0; r_vld_sync marks when the chain holds real samples,
  // so a WR already high at reset release cannot fake a rising edge.
  assign w_event = r_armed & w_wr_s & ~r_wr_hist;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr_sync  <= '0;
      r_a0_sync  <= '0;
      r_d_sync   <= '0;
      r_vld_sync <= '0;
      r_wr_hist  <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], WR};
      r_a0_sync  <= {r_a0_sync[SYNC_STAGES-2:0], A0};
      r_d_sync   <= {r_d_sync[SYNC_STAGES-2:0], D};
      r_vld_sync <= {r_vld_sync[SYNC_STAGES-2:0], 1'b1};
      r_wr_hist  <= w_wr_s;
      if (w_vld_s && !w_wr_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state        <= ST_LO;
      r_addr         <= '0;
      r_lo           <= '0;
      r_reg_we       <= 1'b0;
      r_reg_addr     <= '0;
      r_reg_data     <= '0;
      r_half_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_addr         <= w_addr_nx;
      r_lo           <= w_lo_nx;
      r_reg_we       <= w_we_nx;
      r_reg_addr     <= w_reg_addr_nx;
      r_reg_data     <= w_reg_data_nx;
      r_half_pending <= (w_state_nx == ST_HI);
    end
  end

  // Nibble assembly: address nibbles restart the byte, data nibbles alternate low/high.
  always_comb begin
    w_state_nx    = r_state;
    w_addr_nx     = r_addr;
    w_lo_nx       = r_lo;
    w_we_nx       = 1'b0;
    w_reg_addr_nx = r_reg_addr;
    w_reg_data_nx = r_reg_data;
    if (w_event) begin
      if (w_a0_s) begin
        w_addr_nx  = w_d_s;
        w_lo_nx    = '0;
        w_state_nx = ST_LO;
      end else begin
        case (r_state)
          ST_LO: begin
            w_lo_nx    = w_d_s;
            w_state_nx = ST_HI;
          end
          ST_HI: begin
            w_we_nx       = 1'b1;
            w_reg_addr_nx = r_addr;
            w_reg_data_nx = {w_d_s, r_lo};
            w_lo_nx       = '0;
            w_state_nx    = ST_LO;
`ifdef NIBBLE_BUS_AUTOINC_EN
            w_addr_nx     = r_addr + NIB_W'(1);
`else
            w_addr_nx     = r_addr;
`endif
          end
          default: w_state_nx = ST_LO;
        endcase
      end
    end
  end

  assign reg_we       = r_reg_we;
  assign reg_addr     = r_reg_addr;
  assign reg_data     = r_reg_data;
  assign half_pending = r_half_pending;

endmodule
